// File: rtl/collision_pair_scheduler_if.sv
// Bundles the load, sweep control, calculator handshake and readback signals of collision_pair_scheduler.
// slave is the scheduler side and master is the controller/calculator side.
interface collision_pair_scheduler_if #(
   parameter int WIDTH = 32,
   parameter int IDX_W = 4
);
   logic             ld_en;
   logic [IDX_W-1:0] ld_idx;
   logic [WIDTH-1:0] ld_x, ld_y, ld_vx, ld_vy;
   logic             start;
   logic             busy;
   logic             done;
   logic [7:0]       coll_count;
   logic             calc_start;
   logic [WIDTH-1:0] x0, y0, v0_x, v0_y, x1, y1, v1_x, v1_y;
   logic             calc_done;
   logic [WIDTH-1:0] new_v0_x, new_v0_y, new_v1_x, new_v1_y;
   logic [IDX_W-1:0] rd_idx;
   logic [WIDTH-1:0] rd_x, rd_y, rd_vx, rd_vy;

   modport slave (
      input  ld_en, ld_idx, ld_x, ld_y, ld_vx, ld_vy, start,
      input  calc_done, new_v0_x, new_v0_y, new_v1_x, new_v1_y, rd_idx,
      output busy, done, coll_count, calc_start,
      output x0, y0, v0_x, v0_y, x1, y1, v1_x, v1_y,
      output rd_x, rd_y, rd_vx, rd_vy
   );

   modport master (
      output ld_en, ld_idx, ld_x, ld_y, ld_vx, ld_vy, start,
      output calc_done, new_v0_x, new_v0_y, new_v1_x, new_v1_y, rd_idx,
      input  busy, done, coll_count, calc_start,
      input  x0, y0, v0_x, v0_y, x1, y1, v1_x, v1_y,
      input  rd_x, rd_y, rd_vx, rd_vy
   );
endinterface

// File: rtl/collision_pair_scheduler.sv
// Sweeps all ball pairs (i<j) and issues overlapping pairs to the velocity calculator, writing results back.
// Define APPROACH_CHECK_EN to also require the pair to be approaching (negative relative dot product).
module collision_pair_scheduler #(
   parameter int WIDTH      = 32,
   parameter int FRAC_WIDTH = 30,
   parameter int N_BALLS    = 4,
   parameter int IDX_W      = 4,
   parameter int DIAM_SQ    = 1717987
) (
   input logic clk,
   input logic rst,
   collision_pair_scheduler_if.slave bus
);

   localparam int AW = (N_BALLS > 2) ? $clog2(N_BALLS) : 1;
   localparam logic signed [WIDTH:0] DIAM_EXT = (WIDTH+1)'(DIAM_SQ);

   typedef enum logic [2:0] {IDLE, DIST, CHECK, ISSUE, NEXT, FIN} state_t;

   state_t                   r_state;
   logic [WIDTH-1:0]         r_x [N_BALLS];
   logic [WIDTH-1:0]         r_y [N_BALLS];
   logic [WIDTH-1:0]         r_vx [N_BALLS];
   logic [WIDTH-1:0]         r_vy [N_BALLS];
   logic [IDX_W-1:0]         r_i, r_j;
   logic signed [WIDTH-1:0]  r_dx, r_dy;
   logic                     r_firstIssue, r_busy, r_done, r_calcStart;
   logic [7:0]               r_collCount;
   logic [WIDTH-1:0]         r_x0, r_y0, r_v0x, r_v0y, r_x1, r_y1, r_v1x, r_v1y;

   logic [AW-1:0]            w_ai, w_aj;
   logic                     w_ldOk;
   logic signed [WIDTH:0]    w_d2;
   logic                     w_collide;

   // Fixed-point product: full-width multiply, arithmetic shift, truncate back to WIDTH.
   function automatic logic signed [WIDTH-1:0] fx(input logic signed [WIDTH-1:0] a,
                                                  input logic signed [WIDTH-1:0] b);
      logic signed [2*WIDTH-1:0] p;
      p = (2*WIDTH)'(a) * (2*WIDTH)'(b);
      return WIDTH'(p >>> FRAC_WIDTH);
   endfunction

   assign w_ai   = r_i[AW-1:0];
   assign w_aj   = r_j[AW-1:0];
   assign w_ldOk = int'(bus.ld_idx) < N_BALLS;
   assign w_d2   = (WIDTH+1)'(fx(r_dx, r_dx)) + (WIDTH+1)'(fx(r_dy, r_dy));

`ifdef APPROACH_CHECK_EN
   logic signed [WIDTH-1:0] r_dvx, r_dvy;
   logic signed [WIDTH:0]   w_dot;
   assign w_dot     = (WIDTH+1)'(fx(r_dx, r_dvx)) + (WIDTH+1)'(fx(r_dy, r_dvy));
   assign w_collide = (w_d2 < DIAM_EXT) && !((r_dx == '0) && (r_dy == '0)) && w_dot[WIDTH];
`else
   assign w_collide = (w_d2 < DIAM_EXT) && !((r_dx == '0) && (r_dy == '0));
`endif

   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.coll_count = r_collCount;
   assign bus.calc_start = r_calcStart;
   assign bus.x0   = r_x0;
   assign bus.y0   = r_y0;
   assign bus.v0_x = r_v0x;
   assign bus.v0_y = r_v0y;
   assign bus.x1   = r_x1;
   assign bus.y1   = r_y1;
   assign bus.v1_x = r_v1x;
   assign bus.v1_y = r_v1y;

   // Readback returns zero for indices outside the register file.
   always_comb begin
      bus.rd_x  = '0;
      bus.rd_y  = '0;
      bus.rd_vx = '0;
      bus.rd_vy = '0;
      if (int'(bus.rd_idx) < N_BALLS) begin
         bus.rd_x  = r_x[bus.rd_idx[AW-1:0]];
         bus.rd_y  = r_y[bus.rd_idx[AW-1:0]];
         bus.rd_vx = r_vx[bus.rd_idx[AW-1:0]];
         bus.rd_vy = r_vy[bus.rd_idx[AW-1:0]];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         for (int k = 0; k < N_BALLS; k++) begin
            r_x[k]  <= '0;
            r_y[k]  <= '0;
            r_vx[k] <= '0;
            r_vy[k] <= '0;
         end
         r_i          <= '0;
         r_j          <= '0;
         r_dx         <= '0;
         r_dy         <= '0;
`ifdef APPROACH_CHECK_EN
         r_dvx        <= '0;
         r_dvy        <= '0;
`endif
         r_firstIssue <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_calcStart  <= 1'b0;
         r_collCount  <= '0;
         r_x0  <= '0; r_y0 <= '0; r_v0x <= '0; r_v0y <= '0;
         r_x1  <= '0; r_y1 <= '0; r_v1x <= '0; r_v1y <= '0;
      end else begin
         r_done      <= 1'b0;
         r_calcStart <= 1'b0;
         case (r_state)
            IDLE: begin
               // A load in the same cycle takes priority and suppresses start.
               if (bus.ld_en) begin
                  if (w_ldOk) begin
                     r_x[bus.ld_idx[AW-1:0]]  <= bus.ld_x;
                     r_y[bus.ld_idx[AW-1:0]]  <= bus.ld_y;
                     r_vx[bus.ld_idx[AW-1:0]] <= bus.ld_vx;
                     r_vy[bus.ld_idx[AW-1:0]] <= bus.ld_vy;
                  end
               end else if (bus.start) begin
                  r_i         <= '0;
                  r_j         <= IDX_W'(1);
                  r_collCount <= '0;
                  r_busy      <= 1'b1;
                  r_state     <= DIST;
               end
            end
            DIST: begin
               r_dx    <= r_x[w_aj] - r_x[w_ai];
               r_dy    <= r_y[w_aj] - r_y[w_ai];
`ifdef APPROACH_CHECK_EN
               r_dvx   <= r_vx[w_aj] - r_vx[w_ai];
               r_dvy   <= r_vy[w_aj] - r_vy[w_ai];
`endif
               r_state <= CHECK;
            end
            CHECK: begin
               if (w_collide) begin
                  r_x0  <= r_x[w_ai]; r_y0 <= r_y[w_ai]; r_v0x <= r_vx[w_ai]; r_v0y <= r_vy[w_ai];
                  r_x1  <= r_x[w_aj]; r_y1 <= r_y[w_aj]; r_v1x <= r_vx[w_aj]; r_v1y <= r_vy[w_aj];
                  r_calcStart  <= 1'b1;
                  r_firstIssue <= 1'b1;
                  r_state      <= ISSUE;
               end else begin
                  r_state <= NEXT;
               end
            end
            ISSUE: begin
               // calc_done during the cycle calc_start is visible belongs to no request of ours.
               if (r_firstIssue) begin
                  r_firstIssue <= 1'b0;
               end else if (bus.calc_done) begin
                  r_vx[w_ai] <= bus.new_v0_x;
                  r_vy[w_ai] <= bus.new_v0_y;
                  r_vx[w_aj] <= bus.new_v1_x;
                  r_vy[w_aj] <= bus.new_v1_y;
                  if (r_collCount != 8'hFF) r_collCount <= r_collCount + 8'd1;
                  r_state <= NEXT;
               end
            end
            NEXT: begin
               if (r_j < IDX_W'(N_BALLS - 1)) begin
                  r_j     <= r_j + IDX_W'(1);
                  r_state <= DIST;
               end else if (r_i < IDX_W'(N_BALLS - 2)) begin
                  r_i     <= r_i + IDX_W'(1);
                  r_j     <= r_i + IDX_W'(2);
                  r_state <= DIST;
               end else begin
                  r_state <= FIN;
               end
            end
            FIN: begin
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_collision_pair_scheduler.sv
// Self-checking bench for collision_pair_scheduler: acts as controller and velocity calculator,
// predicting every pair issue and register write-back from a pair-sweep model of the ball set.
module tb_collision_pair_scheduler;

   localparam int W    = 32;
   localparam int FR   = 30;
   localparam int NB   = 4;
   localparam int IW   = 4;
   localparam int DIAM = 1717987;

   localparam longint HALF = 536870912;
   localparam longint P01  = 107374182;
   localparam longint P003 = 32212255;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   longint mX [NB];
   longint mY [NB];
   longint mVx [NB];
   longint mVy [NB];
   int     mCount;

   collision_pair_scheduler_if #(.WIDTH(W), .IDX_W(IW)) bus ();

   collision_pair_scheduler #(
      .WIDTH(W), .FRAC_WIDTH(FR), .N_BALLS(NB), .IDX_W(IW), .DIAM_SQ(DIAM)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   function automatic longint wrapW(input longint v);
      return (v <<< (64 - W)) >>> (64 - W);
   endfunction

   function automatic longint fxm(input longint a, input longint b);
      return wrapW((a * b) >>> FR);
   endfunction

   // Overlap test on the current ball set, with the approach rule when that build option is on.
   function automatic bit modelCollide(input int i, input int j);
      longint dx, dy, d2;
      bit     hit;
      dx  = wrapW(mX[j] - mX[i]);
      dy  = wrapW(mY[j] - mY[i]);
      d2  = fxm(dx, dx) + fxm(dy, dy);
      hit = (d2 < DIAM) && !(dx == 0 && dy == 0);
`ifdef APPROACH_CHECK_EN
      begin
         longint dot;
         dot = fxm(dx, wrapW(mVx[j] - mVx[i])) + fxm(dy, wrapW(mVy[j] - mVy[i]));
         hit = hit && (dot < 0);
      end
`endif
      return hit;
   endfunction

   function automatic longint randVel();
      return longint'($urandom_range(0, 214748364)) - P01;
   endfunction

   task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic applyStimulus(input int idx, input longint x, input longint y,
                                input longint vx, input longint vy);
      @(negedge clk);
      bus.ld_en  = 1'b1;
      bus.ld_idx = IW'(idx);
      bus.ld_x   = W'(x);
      bus.ld_y   = W'(y);
      bus.ld_vx  = W'(vx);
      bus.ld_vy  = W'(vy);
      if (idx < NB) begin
         mX[idx] = wrapW(x); mY[idx] = wrapW(y); mVx[idx] = wrapW(vx); mVy[idx] = wrapW(vy);
      end
      @(negedge clk);
      bus.ld_en = 1'b0;
   endtask

   task automatic clearInputs();
      bus.ld_en = 1'b0; bus.start = 1'b0; bus.calc_done = 1'b0;
   endtask

   task automatic driveNoise(input bit inject);
      bus.calc_done = 1'b0;
      if (inject) begin
         bus.start  = 1'($urandom_range(0, 1));
         bus.ld_en  = 1'($urandom_range(0, 1));
         bus.ld_idx = IW'($urandom_range(0, NB - 1));
         bus.ld_x   = $urandom; bus.ld_y  = $urandom;
         bus.ld_vx  = $urandom; bus.ld_vy = $urandom;
      end else begin
         bus.start = 1'b0;
         bus.ld_en = 1'b0;
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1;
      clearInputs();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < NB; k++) begin
         mX[k] = 0; mY[k] = 0; mVx[k] = 0; mVy[k] = 0;
      end
      mCount = 0;
   endtask

   task automatic checkRegs(input string tag);
      for (int k = 0; k < NB; k++) begin
         bus.rd_idx = IW'(k);
         #1;
         checkOutput($sformatf("%s:ball%0d", tag, k), {bus.rd_x, bus.rd_y, bus.rd_vx, bus.rd_vy},
                     {W'(mX[k]), W'(mY[k]), W'(mVx[k]), W'(mVy[k])});
      end
      bus.rd_idx = IW'(NB + 3);
      #1;
      checkOutput({tag, ":rdOutOfRange"}, {bus.rd_x, bus.rd_y, bus.rd_vx, bus.rd_vy}, '0);
   endtask

   task automatic loadFourBalls(input longint x1, input longint v0x);
      applyStimulus(0, 0, 0, v0x, 0);
      applyStimulus(1, x1, 0, 0, 0);
      applyStimulus(2, -HALF, HALF, 0, 0);
      applyStimulus(3, HALF, HALF, 0, 0);
   endtask

   // Runs one sweep, answering every pair the model expects and checking timing/results.
   task automatic runSweep(input string tag, input bit inject, input int expCycles, input int fixedLat);
      int cycles, lat;
      bit ok;
      logic [255:0] expOps;
      longint n0x, n0y, n1x, n1y;
      cycles = 0;
      mCount = 0;
      @(negedge clk);
      bus.start = 1'b1;
      for (int i = 0; i < NB - 1; i++) begin
         for (int j = i + 1; j < NB; j++) begin
            if (modelCollide(i, j)) begin
               ok = 1'b0;
               for (int b = 0; b < 500; b++) begin
                  @(negedge clk);
                  cycles++;
                  if (bus.done) break;
                  driveNoise(inject);
                  if (bus.calc_start) begin
                     ok = 1'b1;
                     break;
                  end
               end
               if (!ok) begin
                  clearInputs();
                  checkOutput($sformatf("%s:calcStart(%0d,%0d)", tag, i, j), 0, 1);
                  return;
               end
               expOps = {W'(mX[i]), W'(mY[i]), W'(mVx[i]), W'(mVy[i]),
                         W'(mX[j]), W'(mY[j]), W'(mVx[j]), W'(mVy[j])};
               checkOutput($sformatf("%s:operands(%0d,%0d)", tag, i, j),
                           {bus.x0, bus.y0, bus.v0_x, bus.v0_y, bus.x1, bus.y1, bus.v1_x, bus.v1_y},
                           expOps);
               if ($urandom_range(0, 1) == 1) begin
                  bus.calc_done = 1'b1;
                  bus.new_v0_x = $urandom; bus.new_v0_y = $urandom;
                  bus.new_v1_x = $urandom; bus.new_v1_y = $urandom;
               end
               lat = (fixedLat > 0) ? fixedLat : int'($urandom_range(1, 4));
               for (int k = 0; k < lat; k++) begin
                  @(negedge clk);
                  cycles++;
                  driveNoise(inject);
                  checkOutput({tag, ":opsStable"},
                              {bus.x0, bus.y0, bus.v0_x, bus.v0_y, bus.x1, bus.y1, bus.v1_x, bus.v1_y},
                              expOps);
                  checkOutput({tag, ":busyInIssue"}, bus.busy, 1);
               end
               n0x = randVel(); n0y = randVel(); n1x = randVel(); n1y = randVel();
               bus.calc_done = 1'b1;
               bus.new_v0_x = W'(n0x); bus.new_v0_y = W'(n0y);
               bus.new_v1_x = W'(n1x); bus.new_v1_y = W'(n1y);
               mVx[i] = n0x; mVy[i] = n0y; mVx[j] = n1x; mVy[j] = n1y;
               if (mCount < 255) mCount++;
            end
         end
      end
      ok = 1'b0;
      for (int b = 0; b < 500; b++) begin
         @(negedge clk);
         cycles++;
         if (bus.done) begin
            ok = 1'b1;
            break;
         end
         if (bus.calc_start) checkOutput({tag, ":unexpectedCalcStart"}, 1, 0);
         driveNoise(inject);
      end
      clearInputs();
      checkOutput({tag, ":doneSeen"}, ok, 1);
      if (expCycles >= 0) checkOutput({tag, ":sweepCycles"}, cycles, expCycles);
      checkOutput({tag, ":collCount"}, bus.coll_count, mCount);
      checkOutput({tag, ":busyAfter"}, bus.busy, 0);
      checkRegs(tag);
   endtask

   initial begin
      longint dEq, dLt, f;
      bit ok;
      rst = 1'b1;
      bus.rd_idx = '0;
      bus.ld_idx = '0;
      bus.ld_x = '0; bus.ld_y = '0; bus.ld_vx = '0; bus.ld_vy = '0;
      bus.new_v0_x = '0; bus.new_v0_y = '0; bus.new_v1_x = '0; bus.new_v1_y = '0;
      clearInputs();

      // Reset state
      doReset();
      checkOutput("rstBusyDoneStart", {bus.busy, bus.done, bus.calc_start}, 0);
      checkOutput("rstCollCount", bus.coll_count, 0);
      checkOutput("rstOperands", {bus.x0, bus.y0, bus.v0_x, bus.v0_y, bus.x1, bus.y1, bus.v1_x, bus.v1_y}, 0);
      checkRegs("rst");

      // Four balls on a unit square: no collisions, exact sweep length
      $display("[TB] unit square sweep");
      applyStimulus(0, -HALF, -HALF, 0, 0);
      applyStimulus(1,  HALF, -HALF, 0, 0);
      applyStimulus(2, -HALF,  HALF, 0, 0);
      applyStimulus(3,  HALF,  HALF, 0, 0);
      applyStimulus(9, 1, 2, 3, 4);
      checkRegs("loadIgnoreOutOfRange");
      runSweep("square", 1'b0, 20, 0);
      checkOutput("squareCollCountZero", bus.coll_count, 0);

      // start together with ld_en is ignored
      @(negedge clk);
      bus.start = 1'b1; bus.ld_en = 1'b1; bus.ld_idx = IW'(9);
      @(negedge clk);
      clearInputs();
      checkOutput("startWithLdIgnored", bus.busy, 0);

      // Approaching overlap: one issue
      $display("[TB] approaching overlap");
      doReset();
      loadFourBalls(P003, P01);
      runSweep("approach", 1'b0, -1, 0);
      checkOutput("approachCollCount", bus.coll_count, 1);

      // Separating overlap
      $display("[TB] separating overlap");
      doReset();
      loadFourBalls(P003, -P01);
      runSweep("separate", 1'b0, -1, 0);
`ifdef APPROACH_CHECK_EN
      checkOutput("separateCollCount", bus.coll_count, 0);
`else
      checkOutput("separateCollCount", bus.coll_count, 1);
`endif

      // Boundary: d2 == DIAM_SQ is not a collision, DIAM_SQ-1 is
      dEq = -1; dLt = -1;
      for (longint d = 42949000; d < 42951000; d++) begin
         f = fxm(d, d);
         if (f == DIAM - 1 && dLt < 0) dLt = d;
         if (f == DIAM && dEq < 0) dEq = d;
      end
      $display("[TB] boundary offsets eq=%0d lt=%0d", dEq, dLt);
      doReset();
      loadFourBalls(dEq, P01);
      runSweep("boundaryEq", 1'b0, 20, 0);
      checkOutput("boundaryEqCollCount", bus.coll_count, 0);
      doReset();
      loadFourBalls(dLt, P01);
      runSweep("boundaryLt", 1'b0, -1, 0);
      checkOutput("boundaryLtCollCount", bus.coll_count, 1);

      // Calculator stalls for 50 cycles
      $display("[TB] long calculator stall");
      doReset();
      loadFourBalls(P003, P01);
      runSweep("stall", 1'b0, -1, 50);

      // Reset in the middle of a calculator wait
      $display("[TB] reset during issue");
      doReset();
      loadFourBalls(P003, P01);
      @(negedge clk);
      bus.start = 1'b1;
      ok = 1'b0;
      for (int b = 0; b < 100; b++) begin
         @(negedge clk);
         bus.start = 1'b0;
         if (bus.calc_start) begin
            ok = 1'b1;
            break;
         end
      end
      checkOutput("midResetCalcStart", ok, 1);
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 20) begin
            rst = 1'b1;
            bus.calc_done = 1'b1;
            bus.new_v0_x = $urandom; bus.new_v0_y = $urandom;
            bus.new_v1_x = $urandom; bus.new_v1_y = $urandom;
         end
      end
      @(negedge clk);
      rst = 1'b0;
      bus.calc_done = 1'b0;
      for (int k = 0; k < NB; k++) begin
         mX[k] = 0; mY[k] = 0; mVx[k] = 0; mVy[k] = 0;
      end
      checkOutput("midResetBusy", bus.busy, 0);
      checkOutput("midResetFlags", {bus.done, bus.calc_start, bus.coll_count}, 0);
      checkOutput("midResetOperands", {bus.x0, bus.y0, bus.v0_x, bus.v0_y, bus.x1, bus.y1, bus.v1_x, bus.v1_y}, 0);
      checkRegs("midReset");

      // Random clustered balls; the last runs inject ignored start/ld_en pulses
      for (int s = 0; s < 6; s++) begin
         $display("[TB] random sweep %0d", s);
         doReset();
         for (int k = 0; k < NB; k++)
            applyStimulus(k, longint'($urandom_range(0, 85899345)), longint'($urandom_range(0, 85899345)),
                          randVel(), randVel());
         runSweep($sformatf("rand%0d", s), (s >= 3), -1, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
